// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA sync/blank generator with a pixel-clock divider
// and a delay pipeline that aligns the renderer's colour with sync and blank.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33,
    parameter int CLK_DIV = 2,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int PIPE_DLY = 2,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW = $clog2(H_TOTAL),
    localparam int VW = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [23:0]   pixel_color,
    output logic [HW-1:0] pixel_x,
    output logic [VW-1:0] pixel_y,
    output logic          pix_en,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_count,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic          VGA_CLK,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_n,
    output logic          VGA_vBLANK,
    output logic          VGA_SYNC_n
);
    localparam int DW = $clog2(CLK_DIV);
    logic [DW-1:0] div_cnt, div_nxt;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic h_last, v_last, hs_a, vs_a, vblank_a;
    logic [PIPE_DLY-1:0] hs_d, vs_d, blank_d, vblank_d;
    logic [PIPE_DLY:0] blank_st;
    logic [23:0] rgb;

    assign pix_en = 32'(div_cnt) == CLK_DIV - 1;
    assign div_nxt = pix_en ? '0 : div_cnt + DW'(1);
    assign h_last = 32'(hcnt) == H_TOTAL - 1;
    assign v_last = 32'(vcnt) == V_TOTAL - 1;
    assign pixel_x = hcnt;
    assign pixel_y = vcnt;
    assign active = 32'(hcnt) < H_ACTIVE && 32'(vcnt) < V_ACTIVE;
    assign line_start = hcnt == '0 && div_cnt == '0;
    assign frame_start = line_start && vcnt == '0;
    assign hs_a = 32'(hcnt) >= H_ACTIVE + H_FP && 32'(hcnt) < H_ACTIVE + H_FP + H_SYNC;
    assign vs_a = 32'(vcnt) >= V_ACTIVE + V_FP && 32'(vcnt) < V_ACTIVE + V_FP + V_SYNC;
    assign vblank_a = 32'(vcnt) >= V_ACTIVE;
    // blank_st[k] is the blank flag delayed k clocks; index 0 is the raw flag
    assign blank_st = {blank_d, ~active};

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt <= '0;
            hcnt <= '0;
            vcnt <= '0;
            frame_count <= '0;
            hs_d <= '0;
            vs_d <= '0;
            blank_d <= '1;
            vblank_d <= '1;
            rgb <= '0;
            VGA_CLK <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            VGA_CLK <= 32'(div_nxt) >= CLK_DIV / 2;
            if (pix_en) begin
                hcnt <= h_last ? '0 : hcnt + HW'(1);
                if (h_last) begin
                    vcnt <= v_last ? '0 : vcnt + VW'(1);
                    if (v_last) frame_count <= frame_count + 16'd1;
                end
            end
            hs_d <= PIPE_DLY'({hs_d, hs_a});
            vs_d <= PIPE_DLY'({vs_d, vs_a});
            blank_d <= blank_st[PIPE_DLY-1:0];
            vblank_d <= PIPE_DLY'({vblank_d, vblank_a});
            rgb <= blank_st[PIPE_DLY-1] ? 24'h0 : pixel_color;
        end
    end

    assign VGA_HS = hs_d[PIPE_DLY-1] ? HS_POL : ~HS_POL;
    assign VGA_VS = vs_d[PIPE_DLY-1] ? VS_POL : ~VS_POL;
    assign VGA_BLANK_n = ~blank_st[PIPE_DLY];
    assign VGA_vBLANK = vblank_d[PIPE_DLY-1];
    assign VGA_SYNC_n = 1'b0;
    assign VGA_R = rgb[23:16];
    assign VGA_G = rgb[15:8];
    assign VGA_B = rgb[7:0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three differently configured generators checked every clock
// against an arithmetic reference model through per-instance scoreboards.
module tb_vga_timing_gen;
    typedef struct packed {
        int ha, hf, hs, hb, va, vf, vs, vb, cd, pd;
        bit hp, vp;
    } cfg_t;

    typedef struct packed {
        logic [15:0] x, y;
        logic pe, act, ls, fs, vclk;
        logic [15:0] fc;
        logic hs, vs, bn, vb, sn;
        logic [23:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [23:0] col_a = '0, col_b = '0, col_c = '0;
    int checks = 0;
    int failures = 0;
    cfg_t ca, cb, cc;
    exp_t qa[$], qb[$], qc[$];

    always #5 clk = ~clk;

    logic [4:0] a_x, a_y;
    logic a_pe, a_act, a_ls, a_fs, a_clk, a_hs, a_vs, a_bn, a_vb, a_sn;
    logic [15:0] a_fc;
    logic [7:0] a_r, a_g, a_b;
    exp_t act_a;
    vga_timing_gen #(.H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4), .V_ACTIVE(10), .V_FP(2),
        .V_SYNC(2), .V_BP(3), .CLK_DIV(2), .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(3)) u_a (
        .clk(clk), .reset(reset), .pixel_color(col_a), .pixel_x(a_x), .pixel_y(a_y),
        .pix_en(a_pe), .active(a_act), .line_start(a_ls), .frame_start(a_fs),
        .frame_count(a_fc), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .VGA_CLK(a_clk),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_n(a_bn), .VGA_vBLANK(a_vb), .VGA_SYNC_n(a_sn));
    assign act_a = {16'(a_x), 16'(a_y), a_pe, a_act, a_ls, a_fs, a_clk, a_fc,
                    a_hs, a_vs, a_bn, a_vb, a_sn, a_r, a_g, a_b};

    logic [3:0] b_x;
    logic [2:0] b_y;
    logic b_pe, b_act, b_ls, b_fs, b_clk, b_hs, b_vs, b_bn, b_vb, b_sn;
    logic [15:0] b_fc;
    logic [7:0] b_r, b_g, b_b;
    exp_t act_b;
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(1), .V_BP(1), .CLK_DIV(3), .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(1)) u_b (
        .clk(clk), .reset(reset), .pixel_color(col_b), .pixel_x(b_x), .pixel_y(b_y),
        .pix_en(b_pe), .active(b_act), .line_start(b_ls), .frame_start(b_fs),
        .frame_count(b_fc), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_CLK(b_clk),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_n(b_bn), .VGA_vBLANK(b_vb), .VGA_SYNC_n(b_sn));
    assign act_b = {16'(b_x), 16'(b_y), b_pe, b_act, b_ls, b_fs, b_clk, b_fc,
                    b_hs, b_vs, b_bn, b_vb, b_sn, b_r, b_g, b_b};

    logic [9:0] c_x, c_y;
    logic c_pe, c_act, c_ls, c_fs, c_clk, c_hs, c_vs, c_bn, c_vb, c_sn;
    logic [15:0] c_fc;
    logic [7:0] c_r, c_g, c_b;
    exp_t act_c;
    vga_timing_gen u_c (
        .clk(clk), .reset(reset), .pixel_color(col_c), .pixel_x(c_x), .pixel_y(c_y),
        .pix_en(c_pe), .active(c_act), .line_start(c_ls), .frame_start(c_fs),
        .frame_count(c_fc), .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b), .VGA_CLK(c_clk),
        .VGA_HS(c_hs), .VGA_VS(c_vs), .VGA_BLANK_n(c_bn), .VGA_vBLANK(c_vb), .VGA_SYNC_n(c_sn));
    assign act_c = {16'(c_x), 16'(c_y), c_pe, c_act, c_ls, c_fs, c_clk, c_fc,
                    c_hs, c_vs, c_bn, c_vb, c_sn, c_r, c_g, c_b};

    // Expected outputs t clocks after reset: t maps to a pixel index, then to x/y/frame;
    // the delayed outputs reflect pixel t-pd and carry the colour driven during t-1.
    function automatic exp_t model(cfg_t c, int t, logic [23:0] col);
        exp_t e;
        int ht, vt, pix, x, y, ln, td, xd, yd;
        bit vis;
        e = '0;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        pix = t / c.cd;
        x = pix % ht;
        ln = pix / ht;
        y = ln % vt;
        e.x = 16'(x);
        e.y = 16'(y);
        e.fc = 16'(ln / vt);
        e.pe = (t % c.cd) == c.cd - 1;
        e.act = x < c.ha && y < c.va;
        e.ls = x == 0 && (t % c.cd) == 0;
        e.fs = e.ls && y == 0;
        e.vclk = (t % c.cd) >= c.cd / 2;
        td = t - c.pd;
        if (td < 0) begin
            e.hs = !c.hp;
            e.vs = !c.vp;
            e.vb = 1'b1;
        end else begin
            xd = (td / c.cd) % ht;
            yd = (td / c.cd / ht) % vt;
            vis = xd < c.ha && yd < c.va;
            e.hs = (xd >= c.ha + c.hf && xd < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
            e.vs = (yd >= c.va + c.vf && yd < c.va + c.vf + c.vs) ? c.vp : !c.vp;
            e.bn = vis;
            e.vb = yd >= c.va;
            e.rgb = vis ? col : 24'h0;
        end
        return e;
    endfunction

    function automatic logic [23:0] coord_col(cfg_t c, int t);
        int ht, pix;
        if (t < 0) return 24'h0;
        ht = c.ha + c.hf + c.hs + c.hb;
        pix = t / c.cd;
        return {8'(pix % ht), 8'((pix / ht) % (c.va + c.vf + c.vs + c.vb)), 8'h00};
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
        end
    endtask

    task automatic cmp(input string n, input exp_t a, input exp_t e);
        chk({n, ".coord"}, {a.x, a.y}, {e.x, e.y});
        chk({n, ".strobe"}, 32'({a.pe, a.act, a.ls, a.fs, a.vclk}),
            32'({e.pe, e.act, e.ls, e.fs, e.vclk}));
        chk({n, ".fcount"}, 32'(a.fc), 32'(e.fc));
        chk({n, ".sync"}, 32'({a.hs, a.vs, a.bn, a.vb, a.sn}), 32'({e.hs, e.vs, e.bn, e.vb, e.sn}));
        chk({n, ".rgb"}, 32'(a.rgb), 32'(e.rgb));
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (qa.size() > 0) cmp("A", act_a, qa.pop_front());
        if (qb.size() > 0) cmp("B", act_b, qb.pop_front());
        if (qc.size() > 0) cmp("C", act_c, qc.pop_front());
    end

    initial begin
        int s;
        bit rst;
        s = 0;
        ca = '{16, 3, 5, 4, 10, 2, 2, 3, 2, 3, 1'b0, 1'b0};
        cb = '{8, 2, 2, 2, 4, 1, 1, 1, 3, 1, 1'b1, 1'b1};
        cc = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 2, 1'b0, 1'b0};
        for (int cyc = 0; cyc < 9000; cyc++) begin
            @(negedge clk);
            rst = cyc < 3 || cyc == 2611 || cyc == 6100 || $urandom_range(0, 2999) == 0;
            reset = !rst;
            if (cyc < 3000) begin
                col_a = 24'($urandom);
                col_b = 24'($urandom);
                col_c = 24'($urandom);
            end else if (cyc < 6000) begin
                col_a = 24'hFFFFFF;
                col_b = 24'hFFFFFF;
                col_c = 24'hFFFFFF;
            end else begin
                col_a = coord_col(ca, s - (ca.pd - 1));
                col_b = 24'($urandom);
                col_c = coord_col(cc, s - (cc.pd - 1));
            end
            s = rst ? 0 : s + 1;
            qa.push_back(model(ca, s, col_a));
            qb.push_back(model(cb, s, col_b));
            qc.push_back(model(cc, s, col_c));
        end
        repeat (2) @(posedge clk);
        #2;
        chk("drain", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA counter/output block.
- Timing is set per pixel, not per 50 MHz clock, and can be sized for any mode.
- Pixel-clock division ratio, sync polarity and pipeline delay are programmable.
- Sits between `clk` and the DE-series VGA DAC pins. Drives pixel coordinates to the renderer and registers the renderer's colour back out, aligned to sync and blank.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (>=2)
- HS_POL, 0, asserted level of VGA_HS
- VS_POL, 0, asserted level of VGA_VS
- PIPE_DLY, 2, clk cycles from a coordinate to the matching output pixel (>=1)
- Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL).

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-low reset
- pixel_color  in  24  {R,G,B} for the coordinate issued PIPE_DLY-1 cycles earlier
- pixel_x  out  HW  current horizontal count (combinational from counter)
- pixel_y  out  VW  current vertical count
- pix_en  out  1  one-clk strobe, last clk of each pixel period
- active  out  1  pixel_x<H_ACTIVE and pixel_y<V_ACTIVE (undelayed)
- line_start  out  1  one-clk pulse at the start of each line
- frame_start  out  1  one-clk pulse at the start of each frame
- frame_count  out  16  completed-frame counter
- VGA_R, VGA_G, VGA_B  out  8 each  colour to DAC
- VGA_CLK  out  1  pixel clock
- VGA_HS, VGA_VS  out  1  syncs
- VGA_BLANK_n  out  1  low outside the active region
- VGA_vBLANK  out  1  high during vertical blanking
- VGA_SYNC_n  out  1  tied 0

Behaviour:
- All state updates on posedge clk. While reset=0 at a clock edge:
  - div_cnt, hcnt, vcnt and frame_count go to 0.
  - Every delay stage loads its inactive value: HS=~HS_POL, VS=~VS_POL, BLANK_n=0, vBLANK=1.
  - RGB=0, VGA_CLK=0.
  - Reset is honoured mid-frame with no partial-line completion.
- div_cnt counts 0..CLK_DIV-1 and wraps. pix_en = (div_cnt==CLK_DIV-1).
- VGA_CLK is a register loading (next div_cnt >= CLK_DIV/2). For CLK_DIV=2 it is high on odd cycles; the rising edge falls mid-pixel.
- hcnt increments only when pix_en=1. When hcnt==H_TOTAL-1, hcnt goes to 0 and vcnt increments.
- vcnt wraps from V_TOTAL-1 to 0 on that same edge, and frame_count increments (mod 2^16).
- line_start = (hcnt==0 && div_cnt==0). frame_start additionally requires vcnt==0. Both are combinational, so the first cycle after reset release is a frame_start.
- Raw timing, computed from the counters:
  - hs_a = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs_a = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
  - blank = !active
  - vblank = vcnt>=V_ACTIVE
- Delay alignment:
  - Each raw signal passes through a PIPE_DLY-stage shift register clocked every clk.
  - The outputs are the last stage. VGA_HS = hs_d ? HS_POL : ~HS_POL; VS likewise. VGA_BLANK_n = ~blank_d.
  - The RGB register loads pixel_color when stage PIPE_DLY-1 is unblanked, otherwise 0. For PIPE_DLY=1, stage 0 is the raw signal.
  - Result: the colour presented at cycle t+PIPE_DLY-1 appears on VGA_R/G/B at t+PIPE_DLY, together with the sync/blank of coordinate cycle t.
- Counter comparisons are at full width with no truncation. H_TOTAL and V_TOTAL need not be powers of two.

Test Plan:
1. Defaults, run 2 frames.
   - Line period = 1600 clk; frame period = 840000 clk.
   - VGA_HS is low for 192 clk, starting 1312 clk after line_start + PIPE_DLY.
   - VGA_VS is low for 2 lines starting at line 490.
   - frame_count steps 0→1→2.
2. Small mode (H 8/2/2/2, V 4/1/1/1, CLK_DIV=3, PIPE_DLY=1).
   - pix_en every 3rd clk; VGA_CLK pattern 0,1,1 repeating.
   - hcnt wraps 13→0; vcnt wraps 6→0.
   - line_start count per frame = 7.
3. Drive pixel_color=24'hFFFFFF constantly.
   - RGB is FFFFFF exactly while VGA_BLANK_n=1.
   - RGB is 0 on every cycle with VGA_BLANK_n=0, including the first blanked cycle of each line.
4. PIPE_DLY=3; drive pixel_color = {pixel_x[7:0], pixel_y[7:0], 8'h00} delayed 2 clk.
   - Each output pixel's R equals its column and G equals its row.
   - First visible pixel R=0, G=0.
5. HS_POL=1, VS_POL=1.
   - Syncs idle low and pulse high with identical timing to scenario 1.
   - During and immediately after reset, VGA_HS=0.
6. Assert reset=0 for 1 clk at hcnt=300, vcnt=200.
   - Next cycle: pixel_x=0, pixel_y=0, frame_start=1, RGB=0, VGA_BLANK_n=0, frame_count=0.
   - Timing then repeats scenario 1 exactly.
